multicycle_addsub: RTL and testbench
====================================

Name: multicycle_addsub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. Processes CHUNK bits per clock, LSB chunk first, and carries between chunks in a register.
- Adds valid/ready handshakes, optional signed saturation and a full flag set (carry, overflow, zero, negative).
- Sits in the datapath in place of wide single-cycle ripple adders where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK, and WIDTH >= 2.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- N (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept an operand
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- addsub  input  1  0 = A+B, 1 = A-B
- sat  input  1  1 = clamp signed overflow to max/min
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- S  output  WIDTH  result
- Cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
- ov_flag  output  1  signed overflow (reported even when saturated)
- zero_flag  output  1  S == 0 (after saturation)
- neg_flag  output  1  S[WIDTH-1] (after saturation)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - in_ready=1, out_valid=0.
  - S=0, Cout=0, ov_flag=0, zero_flag=0, neg_flag=0.
  - Internal carry, chunk counter and operand registers cleared.
  - Asserting reset mid-CALC or in DONE discards the operation; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch A, B (stored as ~B if addsub=1), addsub and sat; set carry register = addsub; clear counter; go to CALC. Inputs are ignored after the accept edge.
  - CALC: in_ready=0. Each cycle, add chunk[cnt] of A, the stored B and the carry register. Write CHUNK sum bits into the result register and update carry; cnt++. The carry into the MSB is captured in the final chunk. After N CALC cycles, go to DONE.
  - DONE: out_valid=1 and outputs stable. On out_ready=1, go to IDLE; out_valid drops next cycle.
- Latency: out_valid rises exactly N clock edges after the accept edge (N+1 cycles of occupancy including IDLE). Throughput is one op per N+2 cycles with out_ready tied high.
- No new request is accepted while in CALC or DONE. in_valid held high waits in IDLE; there is no input skid buffer.
- Arithmetic:
  - raw = A + B' + cin over WIDTH bits.
  - Cout = carry out of bit WIDTH-1.
  - ov_flag = carry into MSB XOR Cout.
- Saturation: if sat=1 and ov_flag=1, S = 0111..1 when the raw MSB is 1 (positive overflow), else 1000..0. Cout and ov_flag still report the raw values.
- zero_flag and neg_flag are computed from the final S and registered along with the result.
- Simultaneous events:
  - out_ready=1 already high when DONE is entered: handshake completes on that edge.
  - in_valid in the same cycle as the DONE handshake is not accepted until IDLE.
- CHUNK=WIDTH (N=1): one CALC cycle; behaviour otherwise identical.
- S and flags hold their last value in IDLE/CALC; they update only on entry to DONE.

Test Plan (WIDTH=16, CHUNK=4, N=4):
1. Reset, then A=0x7FFF, B=0x0001, addsub=0, sat=0 -> out_valid exactly 4 edges after accept; S=0x8000, Cout=0, ov=1, neg=1, zero=0. Repeat with sat=1 -> S=0x7FFF, ov=1, neg=0.
2. A=0xFFFF, B=0x0001, add -> S=0x0000, Cout=1, ov=0, zero=1. Then A=0x0005, B=0x0005, sub -> S=0x0000, Cout=1, zero=1, ov=0.
3. A=0x8000, B=0x0001, sub, sat=0 -> S=0x7FFF, ov=1, Cout=1. With sat=1 -> S=0x8000, neg=1. Also A=0x0003, B=0x0005, sub -> S=0xFFFE, Cout=0, neg=1.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and S stable, in_ready=0; in_valid with new operands is ignored until IDLE. Then raise out_ready -> previous result consumed once and the new op is accepted the cycle after.
5. Reset mid-op: drop rst_n during CALC cnt=2 -> outputs zero and in_ready=1 immediately (async). After release, the next op (0x1234+0x1111) -> S=0x2345.
6. Random 1000 ops, random sat/addsub/out_ready stalls, checked against a reference model. Repeat at CHUNK=1, CHUNK=16 and WIDTH=8/CHUNK=2, checking latency = N each time.

Source files
------------

// File: rtl/multicycle_addsub_if.sv
// rtl/multicycle_addsub_if.sv - operand request / result handshake bundle for multicycle_addsub
interface multicycle_addsub_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             addsub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             ov_flag;
    logic             zero_flag;
    logic             neg_flag;

    modport master (
        output in_valid, A, B, addsub, sat, out_ready,
        input  in_ready, out_valid, S, Cout, ov_flag, zero_flag, neg_flag
    );

    modport slave (
        input  in_valid, A, B, addsub, sat, out_ready,
        output in_ready, out_valid, S, Cout, ov_flag, zero_flag, neg_flag
    );
endinterface

// File: rtl/multicycle_addsub.sv
// rtl/multicycle_addsub.sv - chunk-serial two's-complement adder/subtractor
// CHUNK bits per cycle LSB first, optional signed saturation, registered flags.
module multicycle_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_addsub_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sat_q, sat_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             carry_msb;
    logic             ov_raw;
    logic [WIDTH-1:0] res_full;
    logic [WIDTH-1:0] s_final;

    // Datapath for the current chunk; carry_msb and ov_raw only matter on the last one.
    always_comb begin
        a_chunk   = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk   = b_q[cnt_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        carry_msb = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        ov_raw    = carry_msb ^ chunk_sum[CHUNK];
        res_full  = res_q;
        res_full[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        s_final   = res_full;
        if (sat_q && ov_raw) begin
            s_final = res_full[WIDTH-1] ? SAT_POS : SAT_NEG;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sat_d   = sat_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is A + ~B + 1: invert B once here and seed the carry.
                    a_d     = bus.A;
                    b_d     = bus.addsub ? ~bus.B : bus.B;
                    sat_d   = bus.sat;
                    carry_d = bus.addsub;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                res_d   = res_full;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    s_d     = s_final;
                    cout_d  = chunk_sum[CHUNK];
                    ov_d    = ov_raw;
                    zero_d  = (s_final == '0);
                    neg_d   = s_final[WIDTH-1];
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sat_q   <= sat_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.ov_flag   = ov_q;
    assign bus.zero_flag = zero_q;
    assign bus.neg_flag  = neg_q;
endmodule

// File: tb/tb_multicycle_addsub.sv
// tb/tb_multicycle_addsub.sv - bench for multicycle_addsub
module tb_multicycle_addsub;
    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ov;
        logic        zero;
        logic        neg;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        as;
        logic        st;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_x;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    logic [3:0] done_x = 4'h0;

    always #5 clk = ~clk;

    multicycle_addsub_if #(.WIDTH(16)) bus ();
    multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic as, logic st, int w);
        int unsigned mask, half, bb, sum, raw, co, cm, s;
        exp_t r;
        mask = (32'd1 << w) - 32'd1;
        half = mask >> 1;
        bb   = as ? (~{16'h0, b} & mask) : ({16'h0, b} & mask);
        sum  = ({16'h0, a} & mask) + bb + {31'd0, as};
        raw  = sum & mask;
        co   = (sum >> w) & 32'd1;
        cm   = ((({16'h0, a} & half) + (bb & half) + {31'd0, as}) >> (w - 1)) & 32'd1;
        s    = raw;
        if (st && (cm != co)) s = (((raw >> (w - 1)) & 32'd1) != 0) ? half : half + 32'd1;
        r.s    = s[15:0];
        r.cout = co[0];
        r.ov   = (cm != co);
        r.zero = (s == 0);
        r.neg  = ((s >> (w - 1)) & 32'd1) != 0;
        return r;
    endfunction

    function automatic logic [15:0] pick(int w);
        int unsigned mask;
        mask = (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 7))
            0:       return 16'h0;
            1:       return mask[15:0];
            2:       return 16'(32'd1 << (w - 1));
            3:       return 16'(mask >> 1);
            4:       return 16'h1;
            default: return 16'($urandom & mask);
        endcase
    endfunction

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic as, logic st,
                                logic [15:0] s, logic c, logic ov, logic z, logic ng);
        vec_t v;
        v.a = a; v.b = b; v.as = as; v.st = st;
        v.e.s = s; v.e.cout = c; v.e.ov = ov; v.e.zero = z; v.e.neg = ng;
        return v;
    endfunction

    function automatic logic [21:0] status();
        return {bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.ov_flag, bus.zero_flag, bus.neg_flag};
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input vec_t v, input int stall);
        int   n;
        int   lat;
        exp_t e;
        @(negedge clk);
        bus.A = v.a; bus.B = v.b; bus.addsub = v.as; bus.sat = v.st;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        sb.push_back(v.e);
        #1;
        bus.in_valid = 1'b0;
        bus.A = 16'($urandom); bus.B = 16'($urandom);
        bus.addsub = 1'($urandom); bus.sat = 1'($urandom);
        wait_valid(lat);
        check("latency", 64'(lat), 64'd4);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        check("result", 64'(status()), 64'({2'b01, e}));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("released", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    endtask

    // Randomised runs against the whole-word model, one DUT per geometry.
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int W  = (g == 3) ? 8 : 16;
        localparam int C  = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 2;
        localparam int NN = W / C;
        multicycle_addsub_if #(.WIDTH(W)) xb ();
        multicycle_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk  (clk),
            .rst_n(rst_n_x),
            .bus  (xb.slave)
        );
        exp_t xq[$];

        initial begin
            int   lat;
            int   stall;
            exp_t e;
            xb.in_valid = 1'b0; xb.A = '0; xb.B = '0;
            xb.addsub = 1'b0; xb.sat = 1'b0; xb.out_ready = 1'b0;
            @(negedge rst_n_x);
            wait (rst_n_x === 1'b1);
            for (int i = 0; i < 250; i++) begin
                stall = $urandom_range(0, 3);
                @(negedge clk);
                xb.A = W'(pick(W)); xb.B = W'(pick(W));
                xb.addsub = 1'($urandom); xb.sat = 1'($urandom);
                e = model(16'(xb.A), 16'(xb.B), xb.addsub, xb.sat, W);
                xb.in_valid  = 1'b1;
                xb.out_ready = (stall == 0);
                @(posedge clk);
                xq.push_back(e);
                #1;
                xb.in_valid = 1'b0;
                xb.A = W'($urandom); xb.B = W'($urandom);
                lat = 0;
                while (!xb.out_valid && lat < 60) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check($sformatf("latency_cfg%0d", g), 64'(lat), 64'(NN));
                for (int k = 0; k < stall; k++) begin
                    @(posedge clk); #1;
                end
                e = xq.pop_front();
                check($sformatf("random_cfg%0d", g),
                      64'({xb.in_ready, xb.out_valid, 16'(xb.S), xb.Cout, xb.ov_flag, xb.zero_flag, xb.neg_flag}),
                      64'({2'b01, e}));
                xb.out_ready = 1'b1;
                @(posedge clk); #1;
                xb.out_ready = 1'b0;
            end
            done_x[g] = 1'b1;
        end
    end

    initial begin
        vec_t vt[10];
        int   lat;
        exp_t e;
        vt[0] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        vt[1] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[2] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[3] = mk(16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[4] = mk(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        vt[5] = mk(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
        vt[6] = mk(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[7] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        vt[8] = mk(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
        vt[9] = mk(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0;
        bus.addsub = 1'b0; bus.sat = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b1; rst_n_x = 1'b1;
        #1;
        rst_n = 1'b0; rst_n_x = 1'b0;
        #2;
        check("reset_state", 64'(status()), 64'({2'b10, 20'h0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst_n_x = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vt[i], i % 3);

        // Backpressure: held in DONE while a new request waits on the input.
        @(negedge clk);
        bus.A = 16'h00FF; bus.B = 16'h0001; bus.addsub = 1'b0; bus.sat = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        sb.push_back('{s: 16'h0100, cout: 1'b0, ov: 1'b0, zero: 1'b0, neg: 1'b0});
        #1;
        bus.A = 16'h1000; bus.B = 16'h0001; bus.addsub = 1'b1; bus.sat = 1'b0;
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", 64'(status()), 64'({2'b01, 16'h0100, 4'b0000}));
        end
        e = sb.pop_front();
        check("bp_result", 64'(status()), 64'({2'b01, e}));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_consumed", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
        @(posedge clk);
        sb.push_back('{s: 16'h0FFF, cout: 1'b1, ov: 1'b0, zero: 1'b0, neg: 1'b0});
        #1;
        check("bp_accept", 64'({bus.in_ready, bus.out_valid}), 64'(2'b00));
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp2_latency", 64'(lat), 64'd4);
        e = sb.pop_front();
        check("bp2_result", 64'(status()), 64'({2'b01, e}));
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp2_consumed", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));

        // Asynchronous reset two chunks into a calculation.
        @(negedge clk);
        bus.A = 16'h4000; bus.B = 16'h0001; bus.addsub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_calc", 64'(status()), 64'({2'b10, 20'h0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(mk(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0), 1);

        for (int i = 0; i < 60000 && done_x != 4'hF; i++) @(posedge clk);
        check("random_done", 64'(done_x), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
